result_mem_writer: RTL and testbench
====================================

Name: result_mem_writer

Overview:
- Write-side counterpart of the result frame memory: accepts the processed 8-bit grayscale pixel stream and writes it row-major into the result RAM.
- Generates a linear address from a column/row counter and handles valid/ready flow control.
- Raises done once a full IMG_W x IMG_H frame is stored. The VGA-side reader waits for done before scanning the memory out.

Parameters:
- IMG_W, 640, pixels per row
- IMG_H, 339, rows per frame
- DATA_W, 8, pixel width
- ADDR_W, 18, RAM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a new frame
- in_valid  input  1  in_pixel/in_last valid
- in_ready  output  1  writer can accept a pixel this cycle
- in_pixel  input  DATA_W  pixel value
- in_last  input  1  producer marks final pixel of frame
- mem_addr  output  ADDR_W  RAM write address
- mem_wdata  output  DATA_W  RAM write data
- mem_we  output  1  RAM write enable
- busy  output  1  frame write in progress
- done  output  1  frame complete; level signal, held until next start or rst
- err  output  1  sticky in_last mismatch flag for the current frame

Behaviour:
- Reset (rst=1 at an edge): state IDLE; col=row=0; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. Reset mid-frame aborts; RAM contents are unspecified afterwards.
- FSM states: IDLE, WRITE, DONE.
- IDLE: start -> WRITE; clear col, row, addr, done, err.
- WRITE:
  - in_ready=1 and busy=1 (both combinational from state).
  - Accept when in_valid && in_ready.
  - Next edge after accept: mem_we=1, mem_addr=row*IMG_W+col, mem_wdata=in_pixel. Latency is 1 cycle, and all mem_* outputs are registered.
  - The address is an incrementing linear counter, not a multiplier.
  - Cycles with no accept give mem_we=0 on the next cycle; mem_addr/mem_wdata hold.
- Counters: col increments per accept. At col==IMG_W-1, col wraps to 0 and row increments.
- Final pixel is col==IMG_W-1 && row==IMG_H-1. Accepting it -> DONE. done=1 and in_ready=0 in the same edge that issues the last mem_we.
- in_last checks:
  - in_last=1 on a non-final accept: err=1 and -> DONE immediately (early termination); that pixel is still written.
  - in_last=0 on the final accept: err=1, -> DONE normally.
- DONE:
  - done=1, busy=0, in_ready=0, mem_we=0 after the final write cycle.
  - start -> WRITE, clearing done, err and the counters.
- start while in WRITE is ignored.
- start and rst together: rst wins.
- Throughput: one pixel per clock when in_valid is held high. A full frame takes IMG_W*IMG_H accept cycles.

Decomposition:
- Package result_mem_pkg holds:
  - IMG_W/IMG_H/DATA_W/ADDR_W default constants;
  - the state enum (IDLE, WRITE, DONE);
  - typedefs pixel_t (DATA_W) and addr_t (ADDR_W).
- One sub-module, frame_xy_counter, with ports:
  - inputs clk, rst, clear, inc;
  - outputs col, row, addr, last_px.
- Its addr increments with inc and resets with clear. The FSM and mem register stage live in the top module.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then idle with start=0 -> all outputs 0, in_ready=0 throughout.
- Full frame, IMG_W=4, IMG_H=3 override:
  - Stimulus: start, then 12 back-to-back pixels 0x00..0x0B, in_last on the 12th.
  - Required: mem_we high for 12 consecutive cycles beginning 1 cycle after the first accept; addr 0..11 with data equal to addr; done=1 after the 12th accept; err=0.
- Backpressure gaps, same config:
  - Stimulus: in_valid toggles 1,0,1,0...
  - Required: only accepted pixels write; addr sequence 0..11 with no gaps; mem_we low on idle cycles; row increments after addr 3 and 7.
- Early in_last:
  - Stimulus: in_last on pixel 5 (addr 4).
  - Required: addr 4 written, then DONE with err=1, done=1 and no further writes.
  - Follow-up: start -> err=0, done=0, first write at addr 0.
- Missing in_last: 12 pixels with in_last=0 -> done=1, err=1.
- Mid-frame reset and start handling:
  - rst asserted after 6 accepts -> next cycle state IDLE, mem_we=0, busy=0.
  - A following start restarts at addr 0.
  - start pulsed during WRITE -> ignored, address sequence continues.

Source files
------------

// File: rtl/result_mem_pkg.sv
// Shared constants and types for the result frame memory writer.
package result_mem_pkg;

    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 339;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    typedef logic [DEF_DATA_W-1:0] pixel_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/frame_xy_counter.sv
// Column/row position tracker with a linear address that steps once per pixel.
module frame_xy_counter #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 339,
    parameter int ADDR_W = 18,
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last_px
);

    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(IMG_W - 1));
    assign row_end = (row == ROW_W'(IMG_H - 1));
    assign last_px = col_end && row_end;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (inc) begin
            addr <= addr + ADDR_W'(1);
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/result_mem_writer.sv
// Streams processed pixels row-major into the result RAM and flags frame completion.
module result_mem_writer
    import result_mem_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t            state;
    logic              accept;
    logic              clear;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              last_px;
    logic              unused_xy;

    assign in_ready = (state == WRITE);
    assign busy     = (state == WRITE);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign clear    = start && (state != WRITE);

    // Position is tracked for the final-pixel test only; the address comes from addr.
    assign unused_xy = ^{col, row};

    frame_xy_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_xy (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .inc     (accept),
        .col     (col),
        .row     (row),
        .addr    (addr),
        .last_px (last_px)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr  <= addr;
                mem_wdata <= in_pixel;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= WRITE;
                        err   <= 1'b0;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        // A mismatched in_last still stores the pixel that carried it.
                        if (last_px) begin
                            state <= DONE;
                            if (!in_last) err <= 1'b1;
                        end else if (in_last) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_mem_writer.sv
// Randomized self-checking bench for result_mem_writer on a 4x3 frame.
module tb_result_mem_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_pixel = '0;
    logic          in_last = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int a;
        int d;
        int t;
    } wr_t;

    wr_t wq[$];
    int  exp_d[$];
    int  acc_t[$];

    result_mem_writer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_last   (in_last),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every RAM write shortly after the edge that issued it.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1)
            wq.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        wq.delete();
        exp_d.delete();
        acc_t.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: valid held high, 1: alternating, 2: random
    task automatic drive(input int n, input int mode, input int last_idx,
                         input bit seq, output bit to);
        int i = 0;
        int budget = 400;
        bit ph = 1'b1;
        to = 1'b0;
        while (i < n) begin
            if (budget == 0) begin
                to = 1'b1;
                break;
            end
            budget--;
            in_valid = (mode == 0) ? 1'b1 :
                       (mode == 1) ? ph : 1'($urandom_range(0, 1));
            in_pixel = seq ? DW'(i) : DW'($urandom);
            in_last  = (i == last_idx);
            ph = ~ph;
            if (in_valid && in_ready) begin
                exp_d.push_back(int'(in_pixel));
                acc_t.push_back(cyc + 1);
                i++;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0 ||
            mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b we=%b busy=%b done=%b err=%b addr=%0d data=%0d exp all 0",
                     in_ready, mem_we, busy, done, err, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({in_ready, busy, mem_we, done} !== 4'b0) begin
                failures++;
                $display("FAIL idle_quiet got rdy=%b busy=%b we=%b done=%b exp 0",
                         in_ready, busy, mem_we, done);
            end
        end
    endtask

    task automatic test_full_frame();
        bit to;
        clear_model();
        do_start();
        checks++;
        if ({in_ready, busy, done} !== 3'b110) begin
            failures++;
            $display("FAIL start_state got rdy=%b busy=%b done=%b exp 1 1 0", in_ready, busy, done);
        end
        drive(N, 0, N - 1, 1'b1, to);
        checks++;
        if (to !== 1'b0) begin
            failures++;
            $display("FAIL full_timeout got=%b exp=0", to);
        end
        checks++;
        if ({done, err, in_ready, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL full_status got done=%b err=%b rdy=%b busy=%b exp 1 0 0 0",
                     done, err, in_ready, busy);
        end
        tick();
        checks++;
        if (wq.size() !== N) begin
            failures++;
            $display("FAIL full_count got=%0d exp=%0d", wq.size(), N);
        end else begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (wq[j].a !== j || wq[j].d !== j || wq[j].t !== acc_t[0] + j) begin
                    failures++;
                    $display("FAIL full_write%0d got a=%0d d=%0d t=%0d exp a=%0d d=%0d t=%0d",
                             j, wq[j].a, wq[j].d, wq[j].t, j, j, acc_t[0] + j);
                end
            end
        end
        checks++;
        if (mem_we !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL full_after got we=%b done=%b exp 0 1", mem_we, done);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_model();
        do_start();
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL bp_restart got done=%b err=%b exp 0 0", done, err);
        end
        drive(N, 1, N - 1, 1'b0, to);
        tick();
        checks++;
        if (to !== 1'b0 || wq.size() !== N) begin
            failures++;
            $display("FAIL bp_count got=%0d to=%b exp=%0d", wq.size(), to, N);
        end else begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (wq[j].a !== j || wq[j].d !== exp_d[j] || wq[j].t !== acc_t[j]) begin
                    failures++;
                    $display("FAIL bp_write%0d got a=%0d d=%0d t=%0d exp a=%0d d=%0d t=%0d",
                             j, wq[j].a, wq[j].d, wq[j].t, j, exp_d[j], acc_t[j]);
                end
            end
            checks++;
            if (wq[4].a - wq[3].a !== 1 || wq[8].a - wq[7].a !== 1 || wq[1].t - wq[0].t !== 2) begin
                failures++;
                $display("FAIL bp_rowwrap got a3=%0d a4=%0d a7=%0d a8=%0d gap=%0d exp 3 4 7 8 2",
                         wq[3].a, wq[4].a, wq[7].a, wq[8].a, wq[1].t - wq[0].t);
            end
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL bp_status got done=%b err=%b exp 1 0", done, err);
        end
    endtask

    task automatic test_early_last();
        bit to;
        clear_model();
        do_start();
        drive(5, 2, 4, 1'b0, to);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        in_valid = 1'b0;
        checks++;
        if (to !== 1'b0 || wq.size() !== 5) begin
            failures++;
            $display("FAIL early_count got=%0d to=%b exp=5", wq.size(), to);
        end else begin
            checks++;
            if (wq[4].a !== 4 || wq[4].d !== exp_d[4]) begin
                failures++;
                $display("FAIL early_last_write got a=%0d d=%0d exp a=4 d=%0d",
                         wq[4].a, wq[4].d, exp_d[4]);
            end
        end
        checks++;
        if ({done, err, in_ready, busy} !== 4'b1100) begin
            failures++;
            $display("FAIL early_status got done=%b err=%b rdy=%b busy=%b exp 1 1 0 0",
                     done, err, in_ready, busy);
        end
    endtask

    task automatic test_missing_last();
        bit to;
        clear_model();
        do_start();
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear got done=%b err=%b exp 0 0", done, err);
        end
        drive(N, 2, -1, 1'b0, to);
        tick();
        checks++;
        if (to !== 1'b0 || wq.size() !== N || wq[0].a !== 0 || wq[N-1].a !== N - 1 ||
            wq[N-1].d !== exp_d[N-1]) begin
            failures++;
            $display("FAIL miss_writes got n=%0d to=%b exp n=%0d first addr 0", wq.size(), to, N);
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL miss_status got done=%b err=%b exp 1 1", done, err);
        end
    endtask

    task automatic test_reset_and_start();
        bit to;
        clear_model();
        do_start();
        drive(6, 0, -1, 1'b0, to);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_we, busy, in_ready, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL midreset got we=%b busy=%b rdy=%b done=%b err=%b exp 0",
                     mem_we, busy, in_ready, done, err);
        end
        tick();
        clear_model();
        do_start();
        drive(3, 2, -1, 1'b0, to);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL start_in_write got busy=%b exp=1", busy);
        end
        drive(N - 3, 2, N - 4, 1'b0, to);
        tick();
        checks++;
        if (to !== 1'b0 || wq.size() !== N) begin
            failures++;
            $display("FAIL restart_count got=%0d to=%b exp=%0d", wq.size(), to, N);
        end else begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (wq[j].a !== j || wq[j].d !== exp_d[j]) begin
                    failures++;
                    $display("FAIL restart_write%0d got a=%0d d=%0d exp a=%0d d=%0d",
                             j, wq[j].a, wq[j].d, j, exp_d[j]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL restart_status got done=%b err=%b exp 1 0", done, err);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_and_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
